// File: rtl/bg_addr_gen.sv
// 2-D address/stream generator driving one SPM bank group in random-access mode.
// A start descriptor (base, inner/outer stride and count) becomes registered en/we/re/addr/din strobes.
module bg_addr_gen #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start_i,
  input  logic              cfg_dir_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [ADDR_W-1:0] cfg_istride_i,
  input  logic [CNT_W-1:0]  cfg_icount_i,
  input  logic [ADDR_W-1:0] cfg_ostride_i,
  input  logic [CNT_W-1:0]  cfg_ocount_i,
  input  logic              cfg_abort_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              en_o,
  output logic              we_o,
  output logic              re_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] din_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e              r_state;
  logic                r_dir;
  logic [ADDR_W-1:0]   r_istride;
  logic [ADDR_W-1:0]   r_ostride;
  logic [CNT_W-1:0]    r_icount;
  logic [CNT_W-1:0]    r_ocount;
  logic [CNT_W-1:0]    r_i_idx;
  logic [CNT_W-1:0]    r_o_idx;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [ADDR_W-1:0]   r_row_base;
  logic                r_en;
  logic                r_we;
  logic                r_re;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;

  logic                w_run;
  logic                w_beat;
  logic                w_last_i;
  logic                w_last_o;
  logic [ADDR_W-1:0]   w_next_row;

  assign w_run      = (r_state == StRun);
  // Reads issue every cycle; writes only on an accepted stream beat.
  assign w_beat     = w_run && (r_dir || s_valid_i);
  assign w_last_i   = (r_i_idx == r_icount - CNT_W'(1));
  assign w_last_o   = (r_o_idx == r_ocount - CNT_W'(1));
  assign w_next_row = r_row_base + r_ostride;

  assign s_ready_o = w_run && !r_dir;
  assign en_o      = r_en;
  assign we_o      = r_we;
  assign re_o      = r_re;
  assign addr_o    = r_addr;
  assign din_o     = r_din;
  assign busy_o    = (r_state != StIdle);
  assign done_o    = (r_state == StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_dir      <= 1'b0;
      r_istride  <= '0;
      r_ostride  <= '0;
      r_icount   <= '0;
      r_ocount   <= '0;
      r_i_idx    <= '0;
      r_o_idx    <= '0;
      r_cur_addr <= '0;
      r_row_base <= '0;
      r_en       <= 1'b0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
    end else begin
      r_en <= 1'b0;
      r_we <= 1'b0;
      r_re <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (cfg_start_i) begin
            r_dir      <= cfg_dir_i;
            r_istride  <= cfg_istride_i;
            r_ostride  <= cfg_ostride_i;
            r_icount   <= cfg_icount_i;
            r_ocount   <= cfg_ocount_i;
            r_i_idx    <= '0;
            r_o_idx    <= '0;
            r_cur_addr <= cfg_base_i;
            r_row_base <= cfg_base_i;
            if ((cfg_icount_i != '0) && (cfg_ocount_i != '0)) begin
              r_state <= StRun;
            end else begin
              r_state <= StDone;
            end
          end
        end
        StRun: begin
          if (cfg_abort_i) begin
            // Any beat accepted in this cycle is dropped.
            r_state <= StIdle;
          end else if (w_beat) begin
            r_en   <= 1'b1;
            r_we   <= !r_dir;
            r_re   <= r_dir;
            r_addr <= r_cur_addr;
            if (!r_dir) begin
              r_din <= s_data_i;
            end
            if (w_last_i) begin
              r_i_idx    <= '0;
              r_o_idx    <= r_o_idx + CNT_W'(1);
              r_row_base <= w_next_row;
              r_cur_addr <= w_next_row;
              if (w_last_o) begin
                r_state <= StDone;
              end
            end else begin
              r_i_idx    <= r_i_idx + CNT_W'(1);
              r_cur_addr <= r_cur_addr + r_istride;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule
